data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_ram.sv | 28 ++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder: memory size,
// memory-mapped I/O addresses and the run-control state type.
package dmem_pkg;

    localparam int DMEM_DEPTH = 1024;

    localparam logic [31:0] CYC_ADDR  = 32'hFFFF_FF00;
    localparam logic [31:0] DONE_ADDR = 32'hFFFF_FF04;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic isMmio(input logic [31:0] addr);
        return (addr == CYC_ADDR) || (addr == DONE_ADDR);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data array: one synchronous write port and one asynchronous read
// port sharing a single address.
module dmem_ram #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset; contents survive reset so results stay
    // readable, and resetting a RAM would prevent mapping onto memory macros.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory shared between a core (while RUN) and a host (while HOLD/DONE),
// with a run-control FSM, a RUN-cycle counter and two MMIO words.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwriteM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              core_run,
    input  logic              host_start,
    input  logic              host_clear,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_rvalid,
    output logic [31:0]       host_rdata,
    output logic              done,
    output logic [31:0]       cycles
);

    state_t            state;
    logic              hostAccept;
    logic              ramWe;
    logic [ADDR_W-1:0] ramAddr;
    logic [31:0]       ramWdata;
    logic [31:0]       ramRdata;

    assign host_ready = (state != RUN);
    assign hostAccept = host_valid && host_ready;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        ramWe     = hostAccept && host_we;
        ramAddr   = host_addr;
        ramWdata  = host_wdata;
        readdataM = '0;
        if (state == RUN) begin
            ramWe    = memwriteM && !isMmio(aluoutM);
            ramAddr  = aluoutM[ADDR_W+1:2];
            ramWdata = writedataM;
            if (aluoutM == CYC_ADDR) begin
                readdataM = cycles;
            end else if (aluoutM != DONE_ADDR) begin
                readdataM = ramRdata;
            end
        end
    end

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ramWe),
        .addr  (ramAddr),
        .wdata (ramWdata),
        .rdata (ramRdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HOLD;
            core_run <= 1'b0;
            done     <= 1'b0;
            cycles   <= '0;
        end else begin
            case (state)
                HOLD: begin
                    if (host_start) begin
                        state    <= RUN;
                        core_run <= 1'b1;
                        cycles   <= '0;
                    end
                end
                RUN: begin
                    // The done-store cycle itself is still counted.
                    cycles <= cycles + 32'd1;
                    if (memwriteM && (aluoutM == DONE_ADDR)) begin
                        state    <= DONE;
                        core_run <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    if (host_clear) begin
                        state <= HOLD;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state    <= HOLD;
                    core_run <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Read response is registered, so a read accepted alongside host_start
    // still completes on the first RUN cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= hostAccept && !host_we;
            if (hostAccept && !host_we) begin
                host_rdata <= ramRdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized host/core traffic
// checked against an array-based reference model of the responder.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              memwriteM;
    logic [31:0]       aluoutM;
    logic [31:0]       writedataM;
    logic [31:0]       readdataM;
    logic              core_run;
    logic              host_start;
    logic              host_clear;
    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [31:0]       host_wdata;
    logic              host_rvalid;
    logic [31:0]       host_rdata;
    logic              done;
    logic [31:0]       cycles;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwriteM   (memwriteM),
        .aluoutM     (aluoutM),
        .writedataM  (writedataM),
        .readdataM   (readdataM),
        .core_run    (core_run),
        .host_start  (host_start),
        .host_clear  (host_clear),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .done        (done),
        .cycles      (cycles)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: plain array plus "ever written" flags, a mode and counters.
    typedef enum {M_HOLD, M_RUN, M_DONE} mode_t;
    logic [31:0] mMem   [DEPTH];
    bit          mKnown [DEPTH];
    mode_t       mMode;
    logic [31:0] mCycles;
    bit          mRvalid;
    bit          mRknown;
    logic [31:0] mRdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: observed %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic modelReset();
        mMode   = M_HOLD;
        mCycles = 0;
        mRvalid = 0;
        mRknown = 1;
        mRdata  = 0;
    endtask

    task automatic compareAll();
        int w;
        check("core_run", 32'(core_run), 32'(mMode == M_RUN));
        check("done", 32'(done), 32'(mMode == M_DONE));
        check("host_ready", 32'(host_ready), 32'(mMode != M_RUN));
        check("cycles", cycles, mCycles);
        check("host_rvalid", 32'(host_rvalid), 32'(mRvalid));
        if (mRvalid && mRknown) check("host_rdata", host_rdata, mRdata);
        if (mMode != M_RUN) begin
            check("readdataM_idle", readdataM, 32'h0);
        end else if (aluoutM == CYC_ADDR) begin
            check("readdataM_cyc", readdataM, mCycles);
        end else if (aluoutM == DONE_ADDR) begin
            check("readdataM_done", readdataM, 32'h0);
        end else begin
            w = wordOf(aluoutM);
            if (mKnown[w]) check("readdataM", readdataM, mMem[w]);
        end
    endtask

    task automatic modelStep();
        bit nextRvalid;
        nextRvalid = 0;
        if (!reset) begin
            modelReset();
            return;
        end
        if (mMode == M_RUN) begin
            if (memwriteM) begin
                if (aluoutM == DONE_ADDR) begin
                    mMode = M_DONE;
                end else if (aluoutM != CYC_ADDR) begin
                    mMem[wordOf(aluoutM)]   = writedataM;
                    mKnown[wordOf(aluoutM)] = 1;
                end
            end
            mCycles = mCycles + 1;
        end else begin
            if (host_valid) begin
                if (host_we) begin
                    mMem[host_addr]   = host_wdata;
                    mKnown[host_addr] = 1;
                end else begin
                    nextRvalid = 1;
                    mRdata     = mMem[host_addr];
                    mRknown    = mKnown[host_addr];
                end
            end
            if (mMode == M_HOLD && host_start) begin
                mMode   = M_RUN;
                mCycles = 0;
            end else if (mMode == M_DONE && host_clear) begin
                mMode = M_HOLD;
            end
        end
        mRvalid = nextRvalid;
    endtask

    // Check at the falling edge, advance the model, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        compareAll();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memwriteM  = 0;
        aluoutM    = 0;
        writedataM = 0;
        host_start = 0;
        host_clear = 0;
        host_valid = 0;
        host_we    = 0;
        host_addr  = 0;
        host_wdata = 0;
    endtask

    function automatic logic [31:0] randCoreAddr();
        logic [31:0] a;
        case ($urandom_range(7))
            0:       a = CYC_ADDR;
            1:       a = $urandom;
            default: a = 32'($urandom_range(511));
        endcase
        if (a == DONE_ADDR) a = a ^ 32'h10;
        return a;
    endfunction

    initial begin
        reset = 0;
        idle();
        modelReset();
        #2;
        check("rst_core_run", 32'(core_run), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cycles", cycles, 32'h0);
        check("rst_rvalid", 32'(host_rvalid), 32'h0);
        check("rst_rdata", host_rdata, 32'h0);
        check("rst_readdataM", readdataM, 32'h0);
        check("rst_ready", 32'(host_ready), 32'h1);
        tick();
        tick();
        reset = 1;

        // Host write then read of index 5, latency one cycle.
        host_valid = 1; host_we = 1; host_addr = 5; host_wdata = 32'hDEADBEEF;
        tick();
        host_we = 0;
        tick();
        idle();
        check("hrd_rvalid", 32'(host_rvalid), 32'h1);
        check("hrd_rdata", host_rdata, 32'hDEADBEEF);
        tick();
        check("hrd_rvalid_once", 32'(host_rvalid), 32'h0);

        // Random host traffic in HOLD; clear pulses and core stores are ignored.
        repeat (40) begin
            host_valid = 1'($urandom);
            host_we    = 1'($urandom);
            host_addr  = ADDR_W'(8 + $urandom_range(55));
            host_wdata = $urandom;
            host_clear = ($urandom_range(7) == 0);
            memwriteM  = 1'($urandom);
            aluoutM    = $urandom;
            writedataM = $urandom;
            tick();
        end
        idle();

        // Start coincident with a host read: read still answered in first RUN cycle.
        host_valid = 1; host_addr = 5; host_start = 1;
        tick();
        idle();
        check("start_rd_rvalid", 32'(host_rvalid), 32'h1);
        check("start_rd_rdata", host_rdata, 32'hDEADBEEF);
        check("start_core_run", 32'(core_run), 32'h1);

        // Core store then loads with ignored low bits and address wrap.
        memwriteM = 1; aluoutM = 32'h14; writedataM = 32'h12345678;
        tick();
        memwriteM = 0; aluoutM = 32'h15;
        #1 check("core_ld_lowbits", readdataM, 32'h12345678);
        aluoutM = 32'h14 + 4 * DEPTH;
        #1 check("core_ld_wrap", readdataM, 32'h12345678);
        tick();

        // Host access and start pulse during RUN are ignored.
        host_valid = 1; host_we = 1; host_addr = 5; host_wdata = 32'h0BAD0BAD; host_start = 1;
        #1 check("run_ready", 32'(host_ready), 32'h0);
        tick();
        idle();
        check("run_start_ignored", 32'(core_run), 32'h1);
        aluoutM = 32'h14;
        #1 check("run_host_nowrite", readdataM, 32'h12345678);
        tick();

        // Store to the cycle-counter address must not touch word 0.
        memwriteM = 1; aluoutM = 32'h0; writedataM = 32'hA5A5_0000;
        tick();
        aluoutM = CYC_ADDR; writedataM = 32'h5A5A_FFFF;
        tick();
        memwriteM = 0; aluoutM = 32'h0;
        #1 check("cyc_store_noarray", readdataM, 32'hA5A5_0000);
        tick();

        // Random core traffic with ignored host activity.
        repeat (200) begin
            memwriteM  = 1'($urandom);
            aluoutM    = randCoreAddr();
            writedataM = $urandom;
            host_valid = 1'($urandom);
            host_we    = 1'($urandom);
            host_addr  = ADDR_W'($urandom);
            host_wdata = $urandom;
            host_start = ($urandom_range(7) == 0);
            host_clear = ($urandom_range(7) == 0);
            tick();
        end
        idle();

        memwriteM = 1; aluoutM = DONE_ADDR;
        tick();
        idle();
        check("done_first", 32'(done), 32'h1);

        // Host reads/writes in DONE with cycles and done frozen.
        repeat (20) begin
            host_valid = 1'($urandom);
            host_we    = ($urandom_range(3) == 0);
            host_addr  = ADDR_W'($urandom);
            host_wdata = $urandom;
            host_start = ($urandom_range(7) == 0);
            memwriteM  = 1'($urandom);
            aluoutM    = $urandom;
            tick();
        end
        idle();

        // Clear, restart, 10 RUN cycles then the done store.
        host_clear = 1;
        tick();
        idle();
        check("clear_done", 32'(done), 32'h0);
        check("clear_ready", 32'(host_ready), 32'h1);
        host_start = 1;
        tick();
        idle();
        check("restart_cycles", cycles, 32'h0);
        check("restart_core_run", 32'(core_run), 32'h1);
        repeat (10) begin
            aluoutM = randCoreAddr();
            tick();
        end
        memwriteM = 1; aluoutM = DONE_ADDR; writedataM = $urandom;
        tick();
        idle();
        check("fin_done", 32'(done), 32'h1);
        check("fin_cycles", cycles, 32'd11);
        check("fin_core_run", 32'(core_run), 32'h0);
        check("fin_ready", 32'(host_ready), 32'h1);
        tick();
        tick();
        check("fin_cycles_frozen", cycles, 32'd11);

        // Reset in RUN aborts a pending read response.
        host_clear = 1;
        tick();
        idle();
        host_valid = 1; host_addr = 5; host_start = 1;
        tick();
        idle();
        repeat (3) tick();
        host_valid = 0;
        reset = 0;
        modelReset();
        #1;
        check("mid_rst_core_run", 32'(core_run), 32'h0);
        check("mid_rst_cycles", cycles, 32'h0);
        check("mid_rst_ready", 32'(host_ready), 32'h1);
        check("mid_rst_done", 32'(done), 32'h0);
        check("mid_rst_readdataM", readdataM, 32'h0);
        tick();
        reset = 1;
        // Pending read aborted right at reset.
        host_valid = 1; host_addr = 5; host_start = 1;
        tick();
        idle();
        reset = 0;
        modelReset();
        #1;
        check("abort_rvalid", 32'(host_rvalid), 32'h0);
        check("abort_rdata", host_rdata, 32'h0);
        tick();
        reset = 1;

        // Array survives reset.
        repeat (8) begin
            host_valid = 1; host_we = 0; host_addr = ADDR_W'($urandom);
            tick();
        end
        idle();
        host_valid = 1; host_addr = 5;
        tick();
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
